// File: rtl/pipe_addsub_if.sv
// Handshake and operand/result bundle for the pipelined adder/subtractor.
interface pipe_addsub_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    // Operand source / result sink side
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    // Adder side
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/pipe_addsub.sv
// Pipelined adder/subtractor: the WIDTH-bit carry chain is split into STAGES
// registered segments of SEG bits; one result per cycle, STAGES-cycle latency.
module pipe_addsub #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 4
) (
    input logic         clk,
    input logic         rst,
    pipe_addsub_if.slave bus
);
    localparam int unsigned SEG  = WIDTH / STAGES;
    localparam int unsigned LAST = STAGES - 1;

    if ((WIDTH % STAGES) != 0) begin : g_bad_split
        $error("pipe_addsub: WIDTH must be a multiple of STAGES");
    end

    // Stage registers: valid, skewed operands, partial sum, segment carry-out
    logic [STAGES-1:0] v_r;
    logic [WIDTH-1:0]  a_r [STAGES];
    logic [WIDTH-1:0]  b_r [STAGES];
    logic [WIDTH-1:0]  s_r [STAGES];
    logic [STAGES-1:0] c_r;
    logic              ovf_r;

    // Per-stage inputs and segment results
    logic [STAGES-1:0] v_in;
    logic [WIDTH-1:0]  a_in  [STAGES];
    logic [WIDTH-1:0]  b_in  [STAGES];
    logic [WIDTH-1:0]  s_in  [STAGES];
    logic [STAGES-1:0] c_in;
    logic [SEG:0]      seg   [STAGES];
    logic [WIDTH-1:0]  s_nxt [STAGES];
    logic              ovf_nxt;
    logic              adv;

    // Whole pipe moves together; a full output that is not taken freezes it
    assign adv           = !v_r[LAST] || bus.out_ready;
    assign bus.in_ready  = adv;
    assign bus.out_valid = v_r[LAST];
    assign bus.sum       = s_r[LAST];
    assign bus.cout      = c_r[LAST];
    assign bus.ovf       = ovf_r;

    // Stage input selection and segment adders
    always_comb begin
        v_in    = '0;
        c_in    = '0;
        a_in    = '{default: '0};
        b_in    = '{default: '0};
        s_in    = '{default: '0};
        seg     = '{default: '0};
        s_nxt   = '{default: '0};
        ovf_nxt = 1'b0;

        // Subtract as a + ~b + ~cin
        v_in[0] = bus.in_valid;
        a_in[0] = bus.a;
        b_in[0] = bus.sub ? ~bus.b : bus.b;
        c_in[0] = bus.sub ^ bus.cin;
        s_in[0] = '0;

        for (int unsigned k = 1; k < STAGES; k++) begin
            v_in[k] = v_r[k-1];
            a_in[k] = a_r[k-1];
            b_in[k] = b_r[k-1];
            c_in[k] = c_r[k-1];
            s_in[k] = s_r[k-1];
        end

        for (int unsigned k = 0; k < STAGES; k++) begin
            seg[k] = {1'b0, a_in[k][k*SEG +: SEG]}
                   + {1'b0, b_in[k][k*SEG +: SEG]}
                   + (SEG+1)'(c_in[k]);
            s_nxt[k] = s_in[k];
            s_nxt[k][k*SEG +: SEG] = seg[k][SEG-1:0];
        end

        // Carry into MSB recovered from the MSB sum bit, XOR carry out of MSB
        ovf_nxt = (a_in[LAST][WIDTH-1] ^ b_in[LAST][WIDTH-1] ^ s_nxt[LAST][WIDTH-1])
                ^ seg[LAST][SEG];
    end

    // Pipeline registers; stage data only loads when that stage receives a valid op
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_r   <= '0;
            c_r   <= '0;
            ovf_r <= 1'b0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                a_r[k] <= '0;
                b_r[k] <= '0;
                s_r[k] <= '0;
            end
        end else if (adv) begin
            v_r <= v_in;
            for (int unsigned k = 0; k < STAGES; k++) begin
                if (v_in[k]) begin
                    a_r[k] <= a_in[k];
                    b_r[k] <= b_in[k];
                    s_r[k] <= s_nxt[k];
                    c_r[k] <= seg[k][SEG];
                end
            end
            if (v_in[LAST]) begin
                ovf_r <= ovf_nxt;
            end
        end
    end
endmodule

// File: tb/tb_pipe_addsub.sv
// Directed bench for pipe_addsub (WIDTH=8, STAGES=4).
module tb_pipe_addsub;
    localparam int unsigned WIDTH  = 8;
    localparam int unsigned STAGES = 4;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
    } op_t;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    op_t  ops [16];

    pipe_addsub_if #(.WIDTH(WIDTH)) bus ();

    pipe_addsub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic op_t mk(input logic [7:0] a, input logic [7:0] b,
                               input logic cin, input logic sub);
        op_t o;
        o.a = a; o.b = b; o.cin = cin; o.sub = sub;
        return o;
    endfunction

    // Reference: plain integer arithmetic, returns {ovf, cout, sum}
    function automatic logic [9:0] model(input op_t o);
        logic [8:0] t;
        int         r;
        logic       v;
        if (!o.sub) begin
            t = 9'(o.a) + 9'(o.b) + 9'(o.cin);
            r = int'($signed(o.a)) + int'($signed(o.b)) + int'(o.cin);
            v = (r > 127) || (r < -128);
            return {v, t[8], t[7:0]};
        end else begin
            t = 9'(o.a) - 9'(o.b) - 9'(o.cin);
            r = int'($signed(o.a)) - int'($signed(o.b)) - int'(o.cin);
            v = (r > 127) || (r < -128);
            return {v, ~t[8], t[7:0]};
        end
    endfunction

    // One isolated op: checks acceptance, latency and the result flags
    task automatic single_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                             input logic cin, input logic sub, input logic [7:0] esum,
                             input logic ecout, input logic eovf);
        int lat;
        @(negedge clk);
        bus.a = a; bus.b = b; bus.cin = cin; bus.sub = sub; bus.in_valid = 1'b1;
        #1;
        chk({tag, " in_ready"}, 32'(bus.in_ready), 32'(1));
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk({tag, " latency"}, 32'(lat), 32'(STAGES - 1));
        chk({tag, " sum"},  32'(bus.sum),  32'(esum));
        chk({tag, " cout"}, 32'(bus.cout), 32'(ecout));
        chk({tag, " ovf"},  32'(bus.ovf),  32'(eovf));
    endtask

    // Streams ops[0..n-1] back to back, optionally stalling the sink
    task automatic run_stream(input string name, input int n,
                              input int stall_at, input int stall_len);
        logic [9:0] expq [$];
        logic [9:0] e;
        logic [7:0] held;
        logic       stalled;
        int         idx;
        int         got;
        int         last_out;
        idx = 0; got = 0; last_out = -1; held = '0;
        for (int cyc = 0; cyc < 80 && got < n; cyc++) begin
            @(negedge clk);
            stalled = (stall_len > 0) && (cyc >= stall_at) && (cyc < stall_at + stall_len);
            bus.out_ready = !stalled;
            #1;
            if (stalled) begin
                chk({name, " in_ready stalled"}, 32'(bus.in_ready), 32'(0));
                chk({name, " out_valid stalled"}, 32'(bus.out_valid), 32'(1));
                if (cyc == stall_at) held = bus.sum;
                else chk({name, " sum held"}, 32'(bus.sum), 32'(held));
            end else if (bus.out_valid) begin
                if (expq.size() == 0) begin
                    chk({name, " unexpected result"}, 32'(bus.out_valid), 32'(0));
                end else begin
                    e = expq.pop_front();
                    chk({name, " sum"},  32'(bus.sum),  32'(e[7:0]));
                    chk({name, " cout"}, 32'(bus.cout), 32'(e[8]));
                    chk({name, " ovf"},  32'(bus.ovf),  32'(e[9]));
                    if (stall_len == 0 && last_out >= 0)
                        chk({name, " no gap"}, 32'(cyc), 32'(last_out + 1));
                    last_out = cyc;
                    got++;
                end
            end
            if (idx < n) begin
                bus.a = ops[idx].a; bus.b = ops[idx].b;
                bus.cin = ops[idx].cin; bus.sub = ops[idx].sub;
                bus.in_valid = 1'b1;
                if (bus.in_ready) begin
                    expq.push_back(model(ops[idx]));
                    idx++;
                end
            end else begin
                bus.in_valid = 1'b0;
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        chk({name, " result count"}, 32'(got), 32'(n));
    endtask

    initial begin
        int stale;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;

        // Reset state
        @(posedge clk);
        #1;
        chk("reset out_valid", 32'(bus.out_valid), 32'(0));
        chk("reset sum",       32'(bus.sum),       32'(0));
        chk("reset cout",      32'(bus.cout),      32'(0));
        chk("reset ovf",       32'(bus.ovf),       32'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post-reset in_ready", 32'(bus.in_ready), 32'(1));

        // Add
        single_op("add 05+03", 8'h05, 8'h03, 1'b0, 1'b0, 8'h08, 1'b0, 1'b0);
        single_op("add FF+01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        // Signed overflow / carry-in
        single_op("add 7F+01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        single_op("add 10+20+1", 8'h10, 8'h20, 1'b1, 1'b0, 8'h31, 1'b0, 1'b0);
        // Subtract
        single_op("sub 10-20", 8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0);
        single_op("sub 80-01", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
        single_op("sub 05-05-1", 8'h05, 8'h05, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0);

        // Streaming, no stalls
        ops[0] = mk(8'hAA, 8'h55, 1'b0, 1'b0);
        ops[1] = mk(8'h0F, 8'h01, 1'b0, 1'b0);
        ops[2] = mk(8'h7F, 8'h7F, 1'b1, 1'b0);
        ops[3] = mk(8'h00, 8'h01, 1'b0, 1'b1);
        ops[4] = mk(8'h80, 8'h80, 1'b0, 1'b0);
        ops[5] = mk(8'hFF, 8'hFF, 1'b1, 1'b0);
        run_stream("stream", 6, 0, 0);

        // Backpressure while the pipe is full
        ops[0] = mk(8'h12, 8'h34, 1'b0, 1'b0);
        ops[1] = mk(8'hC8, 8'h64, 1'b1, 1'b0);
        ops[2] = mk(8'h3C, 8'h5A, 1'b0, 1'b1);
        ops[3] = mk(8'h81, 8'h02, 1'b1, 1'b1);
        ops[4] = mk(8'h40, 8'h40, 1'b0, 1'b0);
        ops[5] = mk(8'hF0, 8'h0F, 1'b1, 1'b0);
        ops[6] = mk(8'h7E, 8'h80, 1'b0, 1'b1);
        ops[7] = mk(8'h01, 8'hFE, 1'b1, 1'b0);
        run_stream("backpressure", 8, 5, 3);

        // Asynchronous reset with ops in flight
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.a = 8'h12 + 8'(i); bus.b = 8'h34; bus.cin = 1'b0; bus.sub = 1'b0;
            bus.in_valid = 1'b1;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        chk("pre-reset out_valid", 32'(bus.out_valid), 32'(1));
        chk("pre-reset sum",       32'(bus.sum),       32'(8'h46));
        #1;
        rst = 1'b1;
        #1;
        chk("async reset out_valid", 32'(bus.out_valid), 32'(0));
        chk("async reset sum",       32'(bus.sum),       32'(0));
        chk("async reset cout",      32'(bus.cout),      32'(0));
        chk("async reset ovf",       32'(bus.ovf),       32'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("release in_ready", 32'(bus.in_ready), 32'(1));
        stale = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.out_valid) stale++;
        end
        chk("no stale result", 32'(stale), 32'(0));

        single_op("after reset 22+33", 8'h22, 8'h33, 1'b0, 1'b0, 8'h55, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
